// File: rtl/alu_seq_pkg.sv
// ============================================================================
//  alu_seq_pkg : opcode and state encodings shared by the sequential ALU
//  Rev 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_CMP = 4'b0010,
    OP_NEG = 4'b0011,
    OP_AND = 4'b1000,
    OP_XOR = 4'b1001,
    OP_OR  = 4'b1010,
    OP_NOT = 4'b1011,
    OP_ROR = 4'b1100,
    OP_ROL = 4'b1101,
    OP_SHR = 4'b1110,
    OP_SHL = 4'b1111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Opcodes 01xx are reserved; 11xx are the shift group
  localparam logic [1:0] c_ILLEGAL_HI = 2'b01;
  localparam logic [1:0] c_SHIFT_HI   = 2'b11;

  function automatic logic is_illegal(input logic [3:0] op);
    return op[3:2] == c_ILLEGAL_HI;
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return op[3:2] == c_SHIFT_HI;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_comb.sv
// ============================================================================
//  alu_seq_comb : single-cycle datapath for arithmetic/logic ops, plus the
//                 unsigned compare and error flags used by every opcode
//  Rev 1.0
// ============================================================================
`default_nettype none

module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_op,
  output logic [WIDTH-1:0] o_f,
  output logic             o_carry,
  output logic             o_ovf,
  output logic             o_zero,
  output logic             o_eq,
  output logic             o_gt,
  output logic             o_lt,
  output logic             o_err
);

  localparam int c_MSB = WIDTH - 1;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_neg;
  logic             w_illegal;

  assign w_sum     = {1'b0, i_a} + {1'b0, i_b};
  assign w_dif     = {1'b0, i_a} + {1'b0, ~i_b} + (WIDTH+1)'(1);
  assign w_neg     = '0 - i_b;
  assign w_illegal = is_illegal(i_op);

  always_comb begin
    o_f     = '0;
    o_carry = 1'b0;
    o_ovf   = 1'b0;
    case (op_e'(i_op))
      OP_ADD: begin
        o_f     = w_sum[c_MSB:0];
        o_carry = w_sum[WIDTH];
        o_ovf   = (i_a[c_MSB] == i_b[c_MSB]) && (w_sum[c_MSB] != i_a[c_MSB]);
      end
      OP_SUB: begin
        o_f     = w_dif[c_MSB:0];
        o_carry = w_dif[WIDTH];
        o_ovf   = (i_a[c_MSB] != i_b[c_MSB]) && (w_dif[c_MSB] != i_a[c_MSB]);
      end
      OP_CMP: o_f = i_a;
      OP_NEG: begin
        o_f     = w_neg;
        o_carry = (i_b == '0);
        o_ovf   = (i_b == {1'b1, {(WIDTH-1){1'b0}}});
      end
      OP_AND: o_f = i_a & i_b;
      OP_XOR: o_f = i_a ^ i_b;
      OP_OR:  o_f = i_a | i_b;
      OP_NOT: o_f = ~i_a;
      default: ;
    endcase
    // Reserved opcodes force every flag except err low
    o_zero = !w_illegal && (o_f == '0);
    o_eq   = !w_illegal && (i_a == i_b);
    o_gt   = !w_illegal && (i_a > i_b);
    o_lt   = !w_illegal && (i_a < i_b);
    o_err  = w_illegal;
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq_core.sv
// ============================================================================
//  alu_seq_core : handshaked ALU with IDLE/SHIFT/DONE sequencing.
//  Define ALU_BARREL_SHIFT_EN for single-cycle shifts.        Rev 1.0
// ============================================================================
`default_nettype none

module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             zeroflag,
  output logic             CarryOut,
  output logic             overflow,
  output logic             EQ,
  output logic             GT,
  output logic             LT,
  output logic             err
);

  state_e           r_state, w_next;
  logic [WIDTH-1:0] r_f;
  logic             r_zero, r_carry, r_ovf, r_eq, r_gt, r_lt, r_err;
  logic [1:0]       r_kind;
  logic [SHW-1:0]   r_cnt;

  logic [WIDTH-1:0] w_c_f;
  logic             w_c_carry, w_c_ovf, w_c_zero, w_c_eq, w_c_gt, w_c_lt, w_c_err;
  logic [SHW-1:0]   w_amt;
  logic             w_is_shift;
  logic             w_go_iter;
  logic [WIDTH:0]   w_sh_res;
  logic [WIDTH:0]   w_step;

  // One-bit move; returns {bit shifted out, new value}. Rotates report the wrapped bit.
  function automatic logic [WIDTH:0] shift_step(input logic [1:0] kind, input logic [WIDTH-1:0] v);
    logic [WIDTH:0] res;
    case (kind)
      2'b00:   res = {v[0], v[0], v[WIDTH-1:1]};
      2'b01:   res = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      2'b10:   res = {v[0], 1'b0, v[WIDTH-1:1]};
      default: res = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
    endcase
    return res;
  endfunction

  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .i_a     (A),
    .i_b     (B),
    .i_op    (s),
    .o_f     (w_c_f),
    .o_carry (w_c_carry),
    .o_ovf   (w_c_ovf),
    .o_zero  (w_c_zero),
    .o_eq    (w_c_eq),
    .o_gt    (w_c_gt),
    .o_lt    (w_c_lt),
    .o_err   (w_c_err)
  );

  assign w_amt      = B[SHW-1:0];
  assign w_is_shift = is_shift(s);
  assign w_step     = shift_step(r_kind, r_f);

`ifdef ALU_BARREL_SHIFT_EN
  // Unrolled chain of single-bit steps keeps results identical to the iterative build
  always_comb begin
    w_sh_res = {1'b0, A};
    for (int i = 0; i < (1 << SHW); i++) begin
      if (i < int'(w_amt)) w_sh_res = shift_step(s[1:0], w_sh_res[WIDTH-1:0]);
    end
  end
  assign w_go_iter = 1'b0;
`else
  // Preload for the iterative shifter; also the final answer when the amount is 0
  assign w_sh_res  = {1'b0, A};
  assign w_go_iter = w_is_shift && (w_amt != '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = w_go_iter ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: if (r_cnt == SHW'(1)) w_next = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_f     <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
      r_err   <= 1'b0;
      r_kind  <= 2'b00;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_kind <= s[1:0];
          r_cnt  <= w_amt;
          r_ovf  <= w_c_ovf;
          r_eq   <= w_c_eq;
          r_gt   <= w_c_gt;
          r_lt   <= w_c_lt;
          r_err  <= w_c_err;
          if (w_is_shift) begin
            r_f     <= w_sh_res[WIDTH-1:0];
            r_carry <= w_sh_res[WIDTH];
            r_zero  <= (w_sh_res[WIDTH-1:0] == '0);
          end else begin
            r_f     <= w_c_f;
            r_carry <= w_c_carry;
            r_zero  <= w_c_zero;
          end
        end
        ST_SHIFT: begin
          r_f     <= w_step[WIDTH-1:0];
          r_carry <= w_step[WIDTH];
          r_zero  <= (w_step[WIDTH-1:0] == '0);
          r_cnt   <= r_cnt - SHW'(1);
        end
        default: ;
      endcase
    end
  end

  assign F        = r_f;
  assign zeroflag = r_zero;
  assign CarryOut = r_carry;
  assign overflow = r_ovf;
  assign EQ       = r_eq;
  assign GT       = r_gt;
  assign LT       = r_lt;
  assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_core.sv
// ============================================================================
//  tb_alu_seq_core : directed + random scoreboard bench for alu_seq_core
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_seq_core;

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit c_BARREL = 1'b1;
`else
  localparam bit c_BARREL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] A, B, F;
  logic [3:0] s;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic       zeroflag, CarryOut, overflow, EQ, GT, LT, err;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] f;
    logic [6:0] flg;   // {carry, ovf, zero, eq, gt, lt, err}
    int         lat;
  } exp_t;

  exp_t sb[$];

  alu_seq_core #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .s         (s),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .F         (F),
    .zeroflag  (zeroflag),
    .CarryOut  (CarryOut),
    .overflow  (overflow),
    .EQ        (EQ),
    .GT        (GT),
    .LT        (LT),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t        e;
    logic [15:0] w;
    logic        c, o;
    int          sa, sb_i, r, n;
    sa   = int'($signed(a));
    sb_i = int'($signed(b));
    n    = int'(b[2:0]);
    c    = 1'b0;
    o    = 1'b0;
    e.f  = 8'h00;
    e.lat = 1;
    case (op)
      4'd0: begin
        w = {8'h00, a} + {8'h00, b}; e.f = w[7:0]; c = w[8];
        r = sa + sb_i; o = (r > 127) || (r < -128);
      end
      4'd1: begin
        e.f = a - b; c = (a >= b);
        r = sa - sb_i; o = (r > 127) || (r < -128);
      end
      4'd2: e.f = a;
      4'd3: begin e.f = 8'h00 - b; c = (b == 8'h00); o = (b == 8'h80); end
      4'd8:  e.f = a & b;
      4'd9:  e.f = a ^ b;
      4'd10: e.f = a | b;
      4'd11: e.f = ~a;
      4'd12: begin w = {a, a} >> n; e.f = w[7:0];  c = (n != 0) && e.f[7]; end
      4'd13: begin w = {a, a} << n; e.f = w[15:8]; c = (n != 0) && e.f[0]; end
      4'd14: begin e.f = a >> n; c = (n != 0) && a[n-1]; end
      4'd15: begin e.f = a << n; c = (n != 0) && a[8-n]; end
      default: begin
        e.flg = 7'b0000001;
        return e;
      end
    endcase
    e.flg = {c, o, (e.f == 8'h00), (a == b), (a > b), (a < b), 1'b0};
    if (op[3:2] == 2'b11 && n != 0 && !c_BARREL) e.lat = n + 1;
    return e;
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input int hold);
    exp_t e;
    int   lat;
    sb.push_back(model(op, a, b));
    lat = 0;
    while (!in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
    check({tag, "/ready_in"}, in_ready, 1);
    s = op; A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after acceptance: the DUT must have captured them
    in_valid = 1'b0; A = ~a; B = a ^ 8'h5A; s = 4'b0011;
    lat = 1;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    e = sb.pop_front();
    check({tag, "/latency"}, lat, e.lat);
    check({tag, "/F"}, F, e.f);
    check({tag, "/flags"}, {CarryOut, overflow, zeroflag, EQ, GT, LT, err}, e.flg);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "/hold_F"}, F, e.f);
      check({tag, "/hold_zero"}, zeroflag, e.flg[4]);
      check({tag, "/hold_busy"}, {out_valid, in_ready}, 2'b10);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "/idle_after"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; s = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("reset/F", F, 8'h00);
    check("reset/flags", {CarryOut, overflow, zeroflag, EQ, GT, LT, err}, 7'b0);
    check("reset/handshake", {out_valid, in_ready}, 2'b01);

    run_op("add_ff_ff", 4'b0000, 8'hFF, 8'hFF, 0);
    run_op("add_ovf",   4'b0001 ^ 4'b0001, 8'h7F, 8'h01, 0);
    run_op("sub_borrow",4'b0001, 8'h02, 8'h08, 0);
    run_op("sub_ovf",   4'b0001, 8'h80, 8'h01, 0);
    run_op("ror_f1_3",  4'b1100, 8'hF1, 8'h03, 0);
    run_op("shl_0a_2",  4'b1111, 8'h0A, 8'h02, 0);
    run_op("xor_hold",  4'b1001, 8'hFF, 8'hFF, 3);
    run_op("illegal",   4'b0101, 8'h12, 8'h34, 0);
    run_op("neg_min",   4'b0011, 8'h10, 8'h80, 0);
    run_op("neg_zero",  4'b0011, 8'h05, 8'h00, 0);
    run_op("shr_n0",    4'b1110, 8'h81, 8'h00, 0);
    run_op("shr_n7",    4'b1110, 8'hC1, 8'h07, 0);
    run_op("rol_hiB",   4'b1101, 8'h81, 8'h0D, 0);
    run_op("cmp_eq",    4'b0010, 8'h55, 8'h55, 0);
    run_op("and",       4'b1000, 8'hF0, 8'h3C, 0);
    run_op("or",        4'b1010, 8'hF0, 8'h0F, 0);
    run_op("not",       4'b1011, 8'h00, 8'h01, 1);

    // Reset while the ROL is in flight: nothing may be emitted
    s = 4'b1101; A = 8'h81; B = 8'h05; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rst_mid/out_valid", out_valid, 1'b0);
    check("rst_mid/F", F, 8'h00);
    check("rst_mid/in_ready", in_ready, 1'b1);
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1 seen |= out_valid; end
    check("rst_mid/no_emit", seen, 1'b0);

    for (int k = 0; k < 24; k++) begin
      logic [3:0] op;
      logic [7:0] ra, rb;
      op = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op($sformatf("rand%0d_op%0h", k, op), op, ra, rb, int'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
